ila_cmd_seq: RTL and testbench
==============================

Name: ila_cmd_seq

Overview:
- Command sequencer between the UART byte receiver and the ILA command consumers (config registers, trigger setup, capture start, readout).
- Decodes the opcode in the high nibble of each received byte and gathers a per-opcode number of argument nibbles from consecutive bytes.
- Issues one command strobe per decoded command, waits for the consumer's acknowledge, then pulses done.
- Guards the byte stream with opcode legality, sequence, overrun and inter-byte timeout checks.

Parameters:
- NUM_CMD, 8: legal opcodes are 0..NUM_CMD-1 (max 16).
- ARG_NIBS, 8: maximum argument nibbles per command; o_arg width is 4*ARG_NIBS.
- CMD_LEN, 64'h0: 16 x 4-bit fields. Field [4*op+:4] is the argument length of opcode op, 0..ARG_NIBS.
- TIMEOUT_CYC, 24'd1_000_000: maximum idle cycles between bytes of one command. 0 disables the timeout.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_ready_read  in  1  one-cycle strobe, i_byte valid
- i_byte  in  8  received byte: [7:4] opcode, [3:0] argument nibble
- i_exec_ack  in  1  consumer finished current command
- o_cmd_valid  out  NUM_CMD  one-hot command strobe, held until ack
- o_arg  out  4*ARG_NIBS  collected argument, right-aligned
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse after ack
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  0 OVERRUN, 1 BAD_OP, 2 SEQ, 3 TIMEOUT; holds the last error

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_reset). All outputs are 0, state IDLE, counters 0. Asserting reset mid-command aborts it with no done and no err pulse.
- States: IDLE, ARG, EXEC, DONE.
- IDLE, byte strobe, op = i_byte[7:4]:
  - op >= NUM_CMD: o_err pulses with code 1 (BAD_OP); stay in IDLE.
  - len = CMD_LEN[4*op+:4] = 0: low nibble ignored, o_arg cleared, go to EXEC.
  - len = 1: o_arg = low nibble zero-extended, go to EXEC.
  - len > 1: o_arg = low nibble, remaining count = len-1, go to ARG.
- ARG:
  - Each strobe whose high nibble equals the latched op gives o_arg <= {o_arg, nibble}, so the first nibble ends up most significant. Go to EXEC when the remaining count reaches 0.
  - A strobe whose high nibble differs from op: o_err pulses with code 2 (SEQ), o_arg is cleared, return to IDLE, and the byte is discarded (not re-decoded).
  - Timeout counter clears on every accepted byte and increments otherwise. On reaching TIMEOUT_CYC: o_err pulses with code 3 (TIMEOUT), return to IDLE.
- EXEC:
  - o_cmd_valid[op] = 1 from the cycle after the completing byte; o_arg stable.
  - On i_exec_ack = 1 (same-cycle ack allowed): drop o_cmd_valid next cycle, go to DONE.
  - Any strobe in EXEC or DONE: byte dropped, o_err pulses with code 0 (OVERRUN), state unaffected.
- DONE: o_done = 1 for one cycle, then IDLE. A byte arriving in this cycle is an overrun.
- Latency: a single-byte command shows o_cmd_valid 1 cycle after the strobe. An ack at cycle t gives o_done at t+1 and a new byte accepted from t+2.
- i_exec_ack outside EXEC is ignored.
- len > ARG_NIBS is clamped to ARG_NIBS.
- Register widths: op 4b, count $clog2(ARG_NIBS+1), timeout counter 24b with saturation.

Optional Feature:
- CMD_SEQ_ECHO_EN defined adds ports o_tx_byte[7:0] and o_tx_valid.
  - On o_done: o_tx_valid pulses with {op, 4'h0}.
  - On o_err: o_tx_valid pulses with {4'hE, 2'b00, code}. Error echo wins if both coincide.
  - This gives host-side acknowledgement.
- Undefined: those ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ila_cmd_pkg: state encoding, error-code constants (ERR_OVERRUN=0, ERR_BAD_OP=1, ERR_SEQ=2, ERR_TIMEOUT=3), default CMD_LEN table, echo error prefix 4'hE.
- Sub-module ila_cmd_timeout: loadable saturating counter with clear, enable and expiry flag.

Test Plan:
- CMD_LEN[op3]=0: byte 8'h35, ack 2 cycles later -> o_cmd_valid=8'b00001000 for 3 cycles, o_arg=0, one o_done pulse.
- CMD_LEN[op2]=4: bytes 8'h2A, 8'h2B, 8'h2C, 8'h2D -> o_arg=32'h0000ABCD, o_cmd_valid[2] after the 4th byte.
- NUM_CMD=8: byte 8'h91 -> o_err pulse with code 1, o_busy stays 0, no o_cmd_valid.
- Op2 len 4: byte 8'h21 then 8'h52 -> o_err code 2, back to IDLE; next 8'h35 executes normally.
- TIMEOUT_CYC=100: byte 8'h21, no further bytes -> o_err code 3 exactly 100 cycles later; byte 8'h71 during EXEC -> o_err code 0 with the command still pending.
- Reset pulse during ARG -> all outputs 0 immediately; later 8'h35 executes cleanly. With CMD_SEQ_ECHO_EN defined -> o_tx_byte=8'h30 on done.

Source files
------------

// File: rtl/ila_cmd_pkg.sv
// Shared definitions for the ILA command sequencer: state encoding,
// error codes, the default argument-length table and the echo prefix.
package ila_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0]  ERR_OVERRUN     = 2'd0;
    localparam logic [1:0]  ERR_BAD_OP      = 2'd1;
    localparam logic [1:0]  ERR_SEQ         = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT     = 2'd3;

    localparam logic [63:0] CMD_LEN_DEFAULT = 64'h0;
    localparam logic [3:0]  ECHO_ERR_PREFIX = 4'hE;

    // Argument length of an opcode, clamped to the argument register size.
    function automatic logic [3:0] op_arg_len(input logic [63:0] len_table,
                                              input logic [3:0]  op,
                                              input int unsigned max_nibs);
        logic [3:0] len_v;
        len_v = len_table[{op, 2'b00} +: 4];
        if (32'(len_v) > max_nibs) begin
            len_v = 4'(max_nibs);
        end else begin
            len_v = len_v;
        end
        return len_v;
    endfunction

endpackage

// File: rtl/ila_cmd_timeout.sv
// Inter-byte idle counter: clears to zero, counts while enabled, saturates
// at its maximum, and flags expiry once LIMIT idle cycles have elapsed.
// A LIMIT of zero never expires.
module ila_cmd_timeout #(
    parameter logic [23:0] LIMIT = 24'd1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [23:0] cnt_r;

    // Idle counter with clear priority and saturation.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_r <= 24'd0;
        end else if (i_clr) begin
            cnt_r <= 24'd0;
        end else if (i_en && (cnt_r != 24'hFF_FFFF)) begin
            cnt_r <= cnt_r + 24'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The counter started at zero after the accepting edge, so reaching
    // LIMIT-1 here means the next idle edge is the LIMIT-th one.
    assign o_expire = (LIMIT != 24'd0) && (cnt_r >= (LIMIT - 24'd1));

endmodule

// File: rtl/ila_cmd_seq.sv
// ILA command sequencer: decodes opcode bytes from the UART receiver,
// gathers argument nibbles, strobes the consumer and waits for its ack.
// Optional host echo port enabled by defining CMD_SEQ_ECHO_EN.
module ila_cmd_seq
    import ila_cmd_pkg::*;
#(
    parameter int unsigned NUM_CMD     = 8,
    parameter int unsigned ARG_NIBS    = 8,
    parameter logic [63:0] CMD_LEN     = CMD_LEN_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ready_read,
    input  logic [7:0]            i_byte,
    input  logic                  i_exec_ack,
    output logic [NUM_CMD-1:0]    o_cmd_valid,
    output logic [4*ARG_NIBS-1:0] o_arg,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_err_code
`ifdef CMD_SEQ_ECHO_EN
    ,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_valid
`endif
);

    localparam int ARG_W = 4 * ARG_NIBS;
    localparam int CNT_W = $clog2(ARG_NIBS + 1);

    state_t             state_r, state_n;
    logic [3:0]         op_r, op_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [ARG_W-1:0]   arg_r, arg_n;
    logic [NUM_CMD-1:0] valid_r, valid_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               err_r, err_n;
    logic [1:0]         code_r, code_n;
    logic [3:0]         len_s;
    logic               tmo_clr_s, tmo_en_s, tmo_expire_s;

    ila_cmd_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (tmo_clr_s),
        .i_en     (tmo_en_s),
        .o_expire (tmo_expire_s)
    );

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_n   = state_r;
        op_n      = op_r;
        cnt_n     = cnt_r;
        arg_n     = arg_r;
        err_n     = 1'b0;
        code_n    = code_r;
        tmo_clr_s = 1'b1;
        tmo_en_s  = 1'b0;
        len_s     = op_arg_len(CMD_LEN, i_byte[7:4], ARG_NIBS);
        case (state_r)
            ST_IDLE: begin
                if (!i_ready_read) begin
                    state_n = ST_IDLE;
                end else if (32'(i_byte[7:4]) >= NUM_CMD) begin
                    err_n  = 1'b1;
                    code_n = ERR_BAD_OP;
                end else begin
                    op_n = i_byte[7:4];
                    if (len_s == 4'd0) begin
                        arg_n   = '0;
                        state_n = ST_EXEC;
                    end else if (len_s == 4'd1) begin
                        arg_n   = ARG_W'(i_byte[3:0]);
                        state_n = ST_EXEC;
                    end else begin
                        arg_n   = ARG_W'(i_byte[3:0]);
                        cnt_n   = CNT_W'(len_s - 4'd1);
                        state_n = ST_ARG;
                    end
                end
            end
            ST_ARG: begin
                if (i_ready_read) begin
                    if (i_byte[7:4] == op_r) begin
                        arg_n = (arg_r << 4) | ARG_W'(i_byte[3:0]);
                        cnt_n = cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_n = ST_EXEC;
                        end else begin
                            state_n = ST_ARG;
                        end
                    end else begin
                        // Mismatched opcode: the byte is discarded, not re-decoded.
                        err_n   = 1'b1;
                        code_n  = ERR_SEQ;
                        arg_n   = '0;
                        state_n = ST_IDLE;
                    end
                end else if (tmo_expire_s) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                end else begin
                    tmo_clr_s = 1'b0;
                    tmo_en_s  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (i_ready_read) begin
                    err_n  = 1'b1;
                    code_n = ERR_OVERRUN;
                end else begin
                    err_n = 1'b0;
                end
                if (i_exec_ack) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (i_ready_read) begin
                    err_n  = 1'b1;
                    code_n = ERR_OVERRUN;
                end else begin
                    err_n = 1'b0;
                end
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
        for (int i = 0; i < NUM_CMD; i++) begin
            valid_n[i] = (state_n == ST_EXEC) && (op_n == 4'(i));
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            cnt_r   <= '0;
            arg_r   <= '0;
            valid_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            code_r  <= 2'd0;
        end else begin
            state_r <= state_n;
            op_r    <= op_n;
            cnt_r   <= cnt_n;
            arg_r   <= arg_n;
            valid_r <= valid_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            err_r   <= err_n;
            code_r  <= code_n;
        end
    end

    assign o_cmd_valid = valid_r;
    assign o_arg       = arg_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_err_code  = code_r;

`ifdef CMD_SEQ_ECHO_EN
    logic [7:0] tx_byte_r;
    logic       tx_valid_r;

    // Host echo: error report takes precedence over a done acknowledgement.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_byte_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else if (err_n) begin
            tx_byte_r  <= {ECHO_ERR_PREFIX, 2'b00, code_n};
            tx_valid_r <= 1'b1;
        end else if (done_n) begin
            tx_byte_r  <= {op_r, 4'h0};
            tx_valid_r <= 1'b1;
        end else begin
            tx_byte_r  <= tx_byte_r;
            tx_valid_r <= 1'b0;
        end
    end

    assign o_tx_byte  = tx_byte_r;
    assign o_tx_valid = tx_valid_r;
`endif

endmodule

// File: tb/tb_ila_cmd_seq.sv
// Directed testbench for ila_cmd_seq. Opcode lengths: op1=1, op2=4,
// op5=9 (clamped to 8), others 0; timeout of 100 idle cycles.
module tb_ila_cmd_seq;

    localparam int unsigned NUM_CMD  = 8;
    localparam int unsigned ARG_NIBS = 8;
    localparam logic [63:0] CMD_LEN  = 64'h0000_0000_0090_0410;
    localparam logic [23:0] TMO      = 24'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        ack = 1'b0;
    logic [7:0]  cmd_valid;
    logic [31:0] arg;
    logic        busy, done, err;
    logic [1:0]  err_code;
`ifdef CMD_SEQ_ECHO_EN
    logic [7:0]  tx_byte;
    logic        tx_valid;
`endif

    int vec_cnt = 0;
    int miss_cnt = 0;

    ila_cmd_seq #(
        .NUM_CMD(NUM_CMD), .ARG_NIBS(ARG_NIBS),
        .CMD_LEN(CMD_LEN), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_ready_read(rdy), .i_byte(byte_in),
        .i_exec_ack(ack), .o_cmd_valid(cmd_valid), .o_arg(arg), .o_busy(busy),
        .o_done(done), .o_err(err), .o_err_code(err_code)
`ifdef CMD_SEQ_ECHO_EN
        , .o_tx_byte(tx_byte), .o_tx_valid(tx_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rdy = 1'b1;
        byte_in = b;
        tick();
        rdy = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vec_cnt++;
        if ({cmd_valid, arg, busy, done, err, err_code} !== 45'd0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got valid=%h arg=%h busy=%b done=%b err=%b code=%0d, want all 0",
                     cmd_valid, arg, busy, done, err, err_code);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_len0();
        int vc = 0;
        send(8'h35);
        vec_cnt++;
        if (arg !== 32'h0 || busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL len0_arg: got arg=%h busy=%b, want 0 and 1", arg, busy);
        end
        if (cmd_valid == 8'h08) vc++;
        tick();
        if (cmd_valid == 8'h08) vc++;
        tick();
        if (cmd_valid == 8'h08) vc++;
        do_ack();
        vec_cnt++;
        if (vc !== 3 || cmd_valid !== 8'h00 || done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL len0_exec: got %0d valid cycles, valid=%h done=%b, want 3, 00, 1", vc, cmd_valid, done);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL len0_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_len4();
        send(8'h2A);
        send(8'h2B);
        send(8'h2C);
        vec_cnt++;
        if (cmd_valid !== 8'h00 || busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL len4_partial: got valid=%h busy=%b, want 00 1", cmd_valid, busy);
        end
        send(8'h2D);
        vec_cnt++;
        if (cmd_valid !== 8'h04 || arg !== 32'h0000ABCD) begin
            miss_cnt++;
            $display("FAIL len4_exec: got valid=%h arg=%h, want 04 0000abcd", cmd_valid, arg);
        end
        do_ack();
        tick();
    endtask

    task automatic test_len1_back_to_back();
        send(8'h1F);
        vec_cnt++;
        if (cmd_valid !== 8'h02 || arg !== 32'h0000000F) begin
            miss_cnt++;
            $display("FAIL len1_exec: got valid=%h arg=%h, want 02 0000000f", cmd_valid, arg);
        end
        do_ack();
        tick();
        // Byte accepted two cycles after the ack.
        send(8'h35);
        vec_cnt++;
        if (cmd_valid !== 8'h08 || arg !== 32'h0 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL back_to_back: got valid=%h arg=%h err=%b, want 08 0 0", cmd_valid, arg, err);
        end
        do_ack();
        tick();
    endtask

    task automatic test_clamp();
        for (int i = 1; i <= 7; i++) send(8'h50 | 8'(i));
        vec_cnt++;
        if (cmd_valid !== 8'h00) begin
            miss_cnt++;
            $display("FAIL clamp_partial: got valid=%h, want 00", cmd_valid);
        end
        send(8'h58);
        vec_cnt++;
        if (cmd_valid !== 8'h20 || arg !== 32'h12345678) begin
            miss_cnt++;
            $display("FAIL clamp_exec: got valid=%h arg=%h, want 20 12345678", cmd_valid, arg);
        end
        do_ack();
        tick();
    endtask

    task automatic test_bad_op();
        send(8'h91);
        vec_cnt++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || cmd_valid !== 8'h00) begin
            miss_cnt++;
            $display("FAIL bad_op: got err=%b code=%0d busy=%b valid=%h, want 1 1 0 00", err, err_code, busy, cmd_valid);
        end
`ifdef CMD_SEQ_ECHO_EN
        vec_cnt++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'hE1) begin
            miss_cnt++;
            $display("FAIL echo_err: got tx_valid=%b tx_byte=%h, want 1 e1", tx_valid, tx_byte);
        end
`endif
        tick();
        vec_cnt++;
        if (err !== 1'b0 || err_code !== 2'd1) begin
            miss_cnt++;
            $display("FAIL bad_op_hold: got err=%b code=%0d, want 0 1", err, err_code);
        end
    endtask

    task automatic test_seq();
        send(8'h21);
        send(8'h52);
        vec_cnt++;
        if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || arg !== 32'h0) begin
            miss_cnt++;
            $display("FAIL seq_err: got err=%b code=%0d busy=%b arg=%h, want 1 2 0 0", err, err_code, busy, arg);
        end
        tick();
        send(8'h35);
        vec_cnt++;
        if (cmd_valid !== 8'h08 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL seq_recover: got valid=%h err=%b, want 08 0", cmd_valid, err);
        end
        do_ack();
        tick();
    endtask

    task automatic test_timeout();
        int k;
        send(8'h21);
        k = 0;
        while (k < 200 && err !== 1'b1) begin
            tick();
            k++;
        end
        vec_cnt++;
        if (k !== 100 || err_code !== 2'd3 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL timeout: got err after %0d cycles code=%0d busy=%b, want 100 3 0", k, err_code, busy);
        end
        tick();
    endtask

    task automatic test_overrun();
        send(8'h35);
        send(8'h71);
        vec_cnt++;
        if (err !== 1'b1 || err_code !== 2'd0 || cmd_valid !== 8'h08 || busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL overrun_exec: got err=%b code=%0d valid=%h busy=%b, want 1 0 08 1", err, err_code, cmd_valid, busy);
        end
        do_ack();
        // Byte arriving in the DONE cycle is an overrun and dropped.
        send(8'h35);
        vec_cnt++;
        if (err !== 1'b1 || err_code !== 2'd0 || cmd_valid !== 8'h00 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL overrun_done: got err=%b code=%0d valid=%h busy=%b, want 1 0 00 0", err, err_code, cmd_valid, busy);
        end
        // Ack outside EXEC is ignored.
        do_ack();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_valid !== 8'h00) begin
            miss_cnt++;
            $display("FAIL stray_ack: got done=%b busy=%b valid=%h, want 0 0 00", done, busy, cmd_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h21);
        send(8'h22);
        rst_n = 1'b0;
        #2;
        vec_cnt++;
        if ({cmd_valid, arg, busy, done, err, err_code} !== 45'd0) begin
            miss_cnt++;
            $display("FAIL reset_mid: got valid=%h arg=%h busy=%b done=%b err=%b code=%0d, want all 0",
                     cmd_valid, arg, busy, done, err, err_code);
        end
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if (err !== 1'b0 || done !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_no_pulse: got err=%b done=%b, want 0 0", err, done);
        end
        send(8'h35);
        vec_cnt++;
        if (cmd_valid !== 8'h08 || arg !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset_recover: got valid=%h arg=%h, want 08 0", cmd_valid, arg);
        end
        do_ack();
        vec_cnt++;
        if (done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_recover_done: got done=%b, want 1", done);
        end
`ifdef CMD_SEQ_ECHO_EN
        vec_cnt++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'h30) begin
            miss_cnt++;
            $display("FAIL echo_done: got tx_valid=%b tx_byte=%h, want 1 30", tx_valid, tx_byte);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_len0();
        test_len4();
        test_len1_back_to_back();
        test_clamp();
        test_bad_op();
        test_seq();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
